// File: rtl/tag_array_pkg.sv
// tag_array_pkg: geometry, data types and controller states for the 64x184 tag array
package tag_array_pkg;
  localparam int SETS   = 64;
  localparam int WAYS   = 8;
  localparam int TAG_W  = 23;
  localparam int IDX_W  = 6;
  localparam int DATA_W = WAYS * TAG_W;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [DATA_W-1:0] set_data_t;
  typedef enum logic [2:0] {
    INIT_SETUP,
    INIT_COMMIT,
    IDLE,
    WR_SETUP,
    WR_COMMIT
  } ctrl_state_e;
endpackage

// File: rtl/tag_array_sweep.sv
// tag_array_sweep: clear-sweep set counter, setup/commit phase and done flag
module tag_array_sweep
  import tag_array_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             step,
  output logic [IDX_W-1:0] cnt,
  output logic             last,
  output logic             done
);
  logic [IDX_W-1:0] cnt_d, cnt_q;
  logic             phase_d, phase_q, done_d, done_q;
  assign cnt  = cnt_q;
  assign done = done_q;
  assign last = phase_q && cnt_q == IDX_W'(SETS - 1);
  always_comb begin
    phase_d = start ? 1'b0 : step ? ~phase_q : phase_q;
    cnt_d   = start ? '0 : (step && phase_q) ? cnt_q + IDX_W'(1) : cnt_q;
    done_d  = start ? 1'b0 : (step && last) ? 1'b1 : done_q;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: rtl/tag_array_ctrl.sv
// tag_array_ctrl: sequences lookups, masked tag writes and clear sweeps onto the tag array R0/W0 ports (TAG_ARRAY_CTRL_PERF_EN adds perf counters)
module tag_array_ctrl
  import tag_array_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              lkp_valid,
  output logic              lkp_ready,
  input  logic [IDX_W-1:0]  lkp_idx,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WAYS-1:0]   wr_way_mask,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              flush_req,
  output logic              init_done,
`ifdef TAG_ARRAY_CTRL_PERF_EN
  output logic [31:0]       perf_lkp_cnt,
  output logic [31:0]       perf_wr_cnt,
`endif
  output logic [IDX_W-1:0]  R0_addr,
  output logic              R0_en,
  input  logic [DATA_W-1:0] R0_data,
  output logic [IDX_W-1:0]  W0_addr,
  output logic              W0_en,
  output logic [DATA_W-1:0] W0_data,
  output logic [WAYS-1:0]   W0_mask
);
  ctrl_state_e      state_d, state_q;
  logic [IDX_W-1:0] wr_idx_d, wr_idx_q, sweep_cnt;
  logic [WAYS-1:0]  wr_mask_d, wr_mask_q;
  tag_t             wr_tag_d, wr_tag_q;
  logic             rsp_valid_d, rsp_valid_q;
  logic             idle, init, wr_fire, lkp_fire, sweep_last;
  tag_array_sweep u_sweep (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (idle && flush_req),
    .step    (init),
    .cnt     (sweep_cnt),
    .last    (sweep_last),
    .done    (init_done)
  );
  assign idle      = state_q == IDLE;
  assign init      = state_q == INIT_SETUP || state_q == INIT_COMMIT;
  assign wr_ready  = idle && !flush_req;
  assign lkp_ready = wr_ready && !wr_valid;
  assign wr_fire   = wr_valid && wr_ready;
  assign lkp_fire  = lkp_valid && lkp_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_valid_q ? R0_data : '0;
  assign R0_en     = lkp_fire;
  assign R0_addr   = lkp_fire ? lkp_idx : '0;
  assign W0_en     = state_q == INIT_COMMIT || state_q == WR_COMMIT;
  assign W0_addr   = init ? sweep_cnt : wr_idx_q;
  assign W0_mask   = state_q == INIT_COMMIT ? '1 : state_q == WR_COMMIT ? wr_mask_q : '0;
  assign W0_data   = state_q == WR_COMMIT ? {WAYS{wr_tag_q}} : '0;
  always_comb begin
    state_d     = state_q == INIT_SETUP  ? INIT_COMMIT
                : state_q == INIT_COMMIT ? (sweep_last ? IDLE : INIT_SETUP)
                : state_q == WR_SETUP    ? WR_COMMIT
                : state_q == WR_COMMIT   ? IDLE
                : flush_req              ? INIT_SETUP
                : wr_fire                ? WR_SETUP
                :                          IDLE;
    wr_idx_d    = wr_fire ? wr_idx : wr_idx_q;
    wr_mask_d   = wr_fire ? wr_way_mask : wr_mask_q;
    wr_tag_d    = wr_fire ? wr_tag : wr_tag_q;
    rsp_valid_d = lkp_fire;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= INIT_SETUP;
      wr_idx_q    <= '0;
      wr_mask_q   <= '0;
      wr_tag_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      wr_mask_q   <= wr_mask_d;
      wr_tag_q    <= wr_tag_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
`ifdef TAG_ARRAY_CTRL_PERF_EN
  logic [31:0] perf_lkp_d, perf_lkp_q, perf_wr_d, perf_wr_q;
  assign perf_lkp_cnt = perf_lkp_q;
  assign perf_wr_cnt  = perf_wr_q;
  always_comb begin
    perf_lkp_d = (lkp_fire && !(&perf_lkp_q)) ? perf_lkp_q + 32'd1 : perf_lkp_q;
    perf_wr_d  = (state_q == WR_COMMIT && !(&perf_wr_q)) ? perf_wr_q + 32'd1 : perf_wr_q;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      perf_lkp_q <= '0;
      perf_wr_q  <= '0;
    end else begin
      perf_lkp_q <= perf_lkp_d;
      perf_wr_q  <= perf_wr_d;
    end
  end
`endif
endmodule

// File: tb/tb_tag_array_ctrl.sv
// tb_tag_array_ctrl: self-checking bench with a macro model and a set-level reference array
module tb_tag_array_ctrl;
  logic         clock = 1'b0;
  logic         reset_n, lkp_valid, lkp_ready, rsp_valid, wr_valid, wr_ready, flush_req, init_done;
  logic [5:0]   lkp_idx, wr_idx, R0_addr, W0_addr;
  logic [183:0] rsp_data, R0_data, W0_data;
  logic [7:0]   wr_way_mask, W0_mask;
  logic [22:0]  wr_tag;
  logic         R0_en, W0_en;
`ifdef TAG_ARRAY_CTRL_PERF_EN
  logic [31:0]  perf_lkp_cnt, perf_wr_cnt;
`endif

  tag_array_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_idx(lkp_idx),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_way_mask(wr_way_mask), .wr_tag(wr_tag),
    .flush_req(flush_req), .init_done(init_done),
`ifdef TAG_ARRAY_CTRL_PERF_EN
    .perf_lkp_cnt(perf_lkp_cnt), .perf_wr_cnt(perf_wr_cnt),
`endif
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [183:0] act, input logic [183:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Macro model: reloaded with non-zero junk while reset is held so the sweep must clear it
  logic [183:0] mem [64];
  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= {8{23'h5A5A5}} ^ 184'(i + 1);
    end else begin
      if (W0_en)
        for (int w = 0; w < 8; w++)
          if (W0_mask[w]) mem[W0_addr][w*23 +: 23] <= W0_data[w*23 +: 23];
      if (R0_en) R0_data <= mem[R0_addr];
    end
  end

  // Reference contents of every set as the cache pipeline intends them
  logic [183:0] ref_mem [64];
  bit           mon_en = 1'b0;
  bit           exp_pend = 1'b0;
  logic [183:0] exp_data = '0;
  logic         prev_en = 1'b0;
  logic [5:0]   prev_addr = '0;
  logic [5:0]   log_addr [$];
  logic [7:0]   log_mask [$];
  logic [183:0] log_data [$];
  int           r0_init = 0;

  always @(negedge clock) begin
    if (mon_en) begin
      chk("rsp_valid", rsp_valid, exp_pend);
      chk("rsp_data", rsp_data, exp_pend ? exp_data : '0);
      chk("r0_w0_exclusive", R0_en & W0_en, 0);
      chk("r0_en_on_accept", R0_en, reset_n && lkp_valid && lkp_ready);
      if (R0_en) chk("r0_addr", R0_addr, lkp_idx);
      if (W0_en) begin
        chk("w0_addr_held", W0_addr, prev_addr);
        chk("w0_setup_before_commit", prev_en, 0);
        log_addr.push_back(W0_addr);
        log_mask.push_back(W0_mask);
        log_data.push_back(W0_data);
      end
      if (R0_en && !init_done) r0_init++;
      prev_en   = W0_en;
      prev_addr = W0_addr;
      exp_pend  = reset_n && lkp_valid && lkp_ready;
      exp_data  = ref_mem[lkp_idx];
    end
  end

  int nwr = 0;

  task automatic clear_ref();
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (!init_done && n < 400) begin
      @(posedge clock);
      n++;
      #1;
    end
    chk(name, n, 128);
  endtask

  task automatic do_wr(input logic [5:0] idx, input logic [7:0] m, input logic [22:0] t, input bit settle);
    int n = 0;
    wr_valid = 1'b1; wr_idx = idx; wr_way_mask = m; wr_tag = t;
    @(negedge clock);
    while (!wr_ready && n < 300) begin
      n++;
      @(negedge clock);
    end
    chk("wr_accept", wr_ready, 1);
    @(posedge clock);
    #1 wr_valid = 1'b0;
    for (int w = 0; w < 8; w++) if (m[w]) ref_mem[idx][w*23 +: 23] = t;
    if (settle) begin
      nwr++;
      repeat (2) @(posedge clock);
      #1;
    end
  endtask

  task automatic do_lkp(input logic [5:0] idx, output logic [183:0] d);
    int n = 0;
    lkp_valid = 1'b1; lkp_idx = idx;
    @(negedge clock);
    while (!lkp_ready && n < 300) begin
      n++;
      @(negedge clock);
    end
    chk("lkp_accept", lkp_ready, 1);
    @(posedge clock);
    #1 lkp_valid = 1'b0;
    chk("lkp_rsp_next_cycle", rsp_valid, 1);
    d = rsp_data;
  endtask

  task automatic check_sweep(input string name, input int base);
    int bad = 0;
    chk({name, "_commits"}, log_addr.size() - base, 64);
    for (int i = 0; i < 64 && base + i < log_addr.size(); i++)
      if (log_addr[base+i] != 6'(i) || log_mask[base+i] != 8'hFF || log_data[base+i] != '0) bad++;
    chk({name, "_bad_entries"}, bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [183:0] d, d2;
    logic [183:0] burst [4];
    int n, base, r0_base;
    clear_ref();
    reset_n = 1'b0; flush_req = 1'b0;
    lkp_valid = 1'b1; lkp_idx = 6'd7;
    wr_valid = 1'b1; wr_idx = 6'd3; wr_way_mask = 8'hFF; wr_tag = 23'h1;
    repeat (3) @(posedge clock);
    #1 mon_en = 1'b1;
    chk("rst_init_done", init_done, 0);
    chk("rst_lkp_ready", lkp_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_r0_en", R0_en, 0);
    chk("rst_w0_en", W0_en, 0);
    chk("rst_w0_mask", W0_mask, 0);
    chk("rst_r0_addr", R0_addr, 0);
    chk("rst_w0_addr", W0_addr, 0);

    wr_valid = 1'b0;
    reset_n = 1'b1;
    base = log_addr.size();
    r0_base = r0_init;
    wait_init("init_done_latency");
    lkp_valid = 1'b0;
    check_sweep("init_sweep", base);
    chk("r0_during_init", r0_init - r0_base, 0);
    do_lkp(6'd0, d);
    chk("set0_cleared", d, 0);

    do_wr(6'd5, 8'b0000_0100, 23'h1ABCDE, 1'b1);
    do_lkp(6'd5, d);
    chk("idx5_way2_tag", d[46 +: 23], 23'h1ABCDE);
    d2 = d;
    d2[46 +: 23] = '0;
    chk("idx5_other_ways", d2, 0);

    do_wr(6'd5, 8'h00, 23'h7FFFFF, 1'b1);
    chk("mask0_commit_addr", log_addr[log_addr.size()-1], 5);
    chk("mask0_commit_mask", log_mask[log_mask.size()-1], 0);
    do_lkp(6'd5, d);
    chk("mask0_no_change", d[46 +: 23], 23'h1ABCDE);

    wr_valid = 1'b1; wr_idx = 6'd9; wr_way_mask = 8'h81; wr_tag = 23'h055AA1;
    lkp_valid = 1'b1; lkp_idx = 6'd9;
    @(negedge clock);
    chk("prio_lkp_ready", lkp_ready, 0);
    chk("prio_wr_ready", wr_ready, 1);
    @(posedge clock);
    #1 wr_valid = 1'b0;
    ref_mem[9][0 +: 23] = 23'h055AA1;
    ref_mem[9][161 +: 23] = 23'h055AA1;
    nwr++;
    n = 0;
    @(negedge clock);
    while (!lkp_ready && n < 50) begin
      n++;
      @(negedge clock);
    end
    chk("lkp_stall_cycles", n, 2);
    @(posedge clock);
    #1 lkp_valid = 1'b0;
    chk("stalled_lkp_way7", rsp_data[161 +: 23], 23'h055AA1);
    chk("stalled_lkp_way0", rsp_data[0 +: 23], 23'h055AA1);

    do_wr(6'd1, 8'h01, 23'h000011, 1'b1);
    do_wr(6'd2, 8'h02, 23'h000022, 1'b1);
    do_wr(6'd3, 8'h04, 23'h000033, 1'b1);
    lkp_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      lkp_idx = 6'(i);
      @(negedge clock);
      chk("burst_ready", lkp_ready, 1);
      @(posedge clock);
      #1;
      chk("burst_rsp_valid", rsp_valid, 1);
      burst[i] = rsp_data;
    end
    lkp_valid = 1'b0;
    chk("burst_rsp1", burst[1][0 +: 23], 23'h000011);
    chk("burst_rsp2", burst[2][23 +: 23], 23'h000022);
    chk("burst_rsp3", burst[3][46 +: 23], 23'h000033);

    do_wr(6'd63, 8'hFF, 23'h3FFFFF, 1'b1);
    do_lkp(6'd63, d);
    chk("idx63_written", d, {8{23'h3FFFFF}});
    flush_req = 1'b1;
    @(posedge clock);
    #1 flush_req = 1'b0;
    clear_ref();
    chk("flush_init_done_low", init_done, 0);
    base = log_addr.size();
    wait_init("flush_latency");
    check_sweep("flush_sweep", base);
    do_lkp(6'd63, d);
    chk("idx63_cleared", d, 0);

`ifdef TAG_ARRAY_CTRL_PERF_EN
    chk("perf_wr_before_reset", perf_wr_cnt, nwr);
`endif
    do_wr(6'd12, 8'hFF, 23'h123456, 1'b0);
    reset_n = 1'b0;
    clear_ref();
    @(posedge clock);
    #1;
    chk("rst_mid_write_no_w0_en", W0_en, 0);
    chk("rst_mid_write_w0_addr", W0_addr, 0);
    chk("rst_mid_write_init_done", init_done, 0);
`ifdef TAG_ARRAY_CTRL_PERF_EN
    chk("rst_perf_wr_cnt", perf_wr_cnt, 0);
    chk("rst_perf_lkp_cnt", perf_lkp_cnt, 0);
`endif
    reset_n = 1'b1;
    base = log_addr.size();
    wait_init("restart_latency");
    check_sweep("restart_sweep", base);
    do_lkp(6'd12, d);
    chk("idx12_abandoned", d, 0);

    repeat (2) @(posedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
